// File: rtl/alu_issue_pkg.sv
// Shared ALU definitions: one-hot opcode width, bit positions and RV32I field codes.
// Used by the issue stage, its decoder and anything modelling the combinational ALU.
// No logic here beyond a small one-hot helper.
package alu_issue_pkg;

    localparam int NR_ALU = 10;

    // One-hot bit positions of alu_op
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_AND  = 2;
    localparam int ALU_OR   = 3;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 5;
    localparam int ALU_SRL  = 6;
    localparam int ALU_SRA  = 7;
    localparam int ALU_SLT  = 8;
    localparam int ALU_SLTU = 9;

    // funct3 codes for OP / OP-IMM
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct7 codes: base encoding and the alternate (sub/sra) encoding
    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    function automatic logic [NR_ALU-1:0] onehot(input int idx);
        onehot = {{(NR_ALU-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Bundle of the issue handshake, the ALU drive/return path and the writeback handshake.
// slave = the issue stage itself; master = upstream/ALU/downstream environment.
// Widths follow the WIDTH/NR_ALU parameters of the instantiating context.
interface alu_issue_if
    import alu_issue_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NR_ALU = alu_issue_pkg::NR_ALU
) ();

    // upstream issue
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic              is_imm;
    logic [WIDTH-1:0]  rs1_val;
    logic [WIDTH-1:0]  rs2_val;
    logic [WIDTH-1:0]  imm;

    // drive into / result from the combinational ALU
    logic [NR_ALU-1:0] alu_op;
    logic [WIDTH-1:0]  alu_in1;
    logic [WIDTH-1:0]  alu_in2;
    logic [WIDTH-1:0]  alu_out;
    logic              alu_valid;

    // downstream writeback
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  result;
    logic              err;

    modport slave (
        input  in_valid, funct3, funct7, is_imm, rs1_val, rs2_val, imm,
        input  alu_out, alu_valid, out_ready,
        output in_ready, alu_op, alu_in1, alu_in2, out_valid, result, err
    );

    modport master (
        output in_valid, funct3, funct7, is_imm, rs1_val, rs2_val, imm,
        output alu_out, alu_valid, out_ready,
        input  in_ready, alu_op, alu_in1, alu_in2, out_valid, result, err
    );

endinterface

// File: rtl/alu_issue_decode.sv
// Combinational RV32I OP/OP-IMM decoder: funct3/funct7/is_imm -> one-hot ALU op.
// Latency: none (pure combinational).
// Backpressure: none; flags illegal encodings and I-type shifts needing shamt masking.
module alu_decode
    import alu_issue_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic              is_imm,
    output logic [NR_ALU-1:0] op,
    output logic              illegal,
    output logic              shamt_mask
);

    logic f7_base;
    logic f7_alt;
    logic is_shift;

    assign f7_base  = (funct7 == F7_BASE);
    assign f7_alt   = (funct7 == F7_ALT);
    assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SR);

    // Select the one-hot op and classify the encoding
    always_comb begin
        op         = '0;
        illegal    = 1'b0;
        shamt_mask = is_imm && is_shift;

        case (funct3)
            F3_ADD:  op = (!is_imm && f7_alt) ? onehot(ALU_SUB) : onehot(ALU_ADD);
            F3_SLL:  op = onehot(ALU_SLL);
            F3_SLT:  op = onehot(ALU_SLT);
            F3_SLTU: op = onehot(ALU_SLTU);
            F3_XOR:  op = onehot(ALU_XOR);
            F3_SR:   op = f7_alt ? onehot(ALU_SRA) : onehot(ALU_SRL);
            F3_OR:   op = onehot(ALU_OR);
            default: op = onehot(ALU_AND);
        endcase

        if (!is_imm) begin
            // register form: funct7 must be base or alt, alt only for sub/sra
            illegal = !(f7_base || f7_alt) ||
                      (f7_alt && (funct3 != F3_ADD) && (funct3 != F3_SR));
        end else begin
            // immediate form: funct7 only carries meaning for shifts; slli has no alt form
            illegal = (is_shift && !(f7_base || f7_alt)) ||
                      ((funct3 == F3_SLL) && f7_alt);
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Two-stage ALU issue: S1 registers decoded op/operands into the ALU, S2 registers the result.
// Latency: 2 cycles accept-to-out_valid; 1 op/cycle sustained when out_ready stays high.
// Backpressure: valid/ready; stalls hold S1 and S2 stable, flush kills both stages.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NR_ALU = alu_issue_pkg::NR_ALU
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    alu_issue_if.slave  bus
);

    logic [NR_ALU-1:0] dec_op;
    logic              dec_illegal;
    logic              dec_shamt;
    logic [WIDTH-1:0]  in2_sel;

    logic              s1_valid;
    logic              s1_illegal;
    logic [NR_ALU-1:0] s1_op;
    logic [WIDTH-1:0]  s1_in1;
    logic [WIDTH-1:0]  s1_in2;

    logic              s2_valid;
    logic              s2_err;
    logic [WIDTH-1:0]  s2_result;

    logic              s2_free;
    logic              accept;
    logic              s1_advance;

    alu_decode u_decode (
        .funct3     (bus.funct3),
        .funct7     (bus.funct7),
        .is_imm     (bus.is_imm),
        .op         (dec_op),
        .illegal    (dec_illegal),
        .shamt_mask (dec_shamt)
    );

    // Immediate shifts only use the low five bits of the immediate as shamt
    assign in2_sel = !bus.is_imm ? bus.rs2_val :
                     dec_shamt   ? {{(WIDTH-5){1'b0}}, bus.imm[4:0]} :
                                   bus.imm;

    assign s2_free    = !s2_valid || bus.out_ready;
    assign bus.in_ready = !flush && (!s1_valid || s2_free);
    assign accept     = bus.in_valid && bus.in_ready;
    assign s1_advance = s1_valid && s2_free;

    // S1: capture decoded op and operands; alu_op is zero whenever S1 is empty or illegal
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_illegal <= 1'b0;
            s1_op      <= '0;
            s1_in1     <= '0;
            s1_in2     <= '0;
        end else if (flush) begin
            s1_valid   <= 1'b0;
            s1_op      <= '0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            s1_illegal <= dec_illegal;
            s1_op      <= dec_illegal ? '0 : dec_op;
            s1_in1     <= bus.rs1_val;
            s1_in2     <= in2_sel;
        end else if (s1_advance) begin
            s1_valid   <= 1'b0;
            s1_op      <= '0;
        end
    end

    // S2: register the ALU result; illegal ops pass through with a zero result and err set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_err    <= 1'b0;
        end else if (flush) begin
            s2_valid  <= 1'b0;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= s1_illegal ? '0 : bus.alu_out;
                s2_err    <= s1_illegal || !bus.alu_valid;
            end
        end
    end

    assign bus.alu_op    = s1_op;
    assign bus.alu_in1   = s1_in1;
    assign bus.alu_in2   = s1_in2;
    assign bus.out_valid = s2_valid;
    assign bus.result    = s2_result;
    assign bus.err       = s2_err;

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits.
REQ-002 SHALL have parameter NR_ALU, default 10: one-hot ALU opcode width.
REQ-003 SHALL have clk  input  1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have rst  input  1: reset, asynchronous and active-high.
REQ-005 SHALL have flush  input  1: synchronous pipeline kill.
REQ-006 SHALL have in_valid  input  1 and in_ready  output  1: upstream issue handshake.
REQ-007 SHALL have funct3  input  3, funct7  input  7, is_imm  input  1: RV32I OP/OP-IMM fields.
REQ-008 SHALL have rs1_val  input  WIDTH, rs2_val  input  WIDTH, imm  input  WIDTH: source values and sign-extended immediate.
REQ-009 SHALL have alu_op  output  NR_ALU, alu_in1  output  WIDTH, alu_in2  output  WIDTH: registered drive into the combinational ALU.
REQ-010 SHALL have alu_out  input  WIDTH and alu_valid  input  1: ALU result and its "op handled" flag.
REQ-011 SHALL have out_valid  output  1, out_ready  input  1, result  output  WIDTH, err  output  1: downstream writeback handshake.

Function
REQ-012 SHALL use one-hot bit positions add0 sub1 and2 or3 xor4 sll5 srl6 sra7 slt8 sltu9.
REQ-013 SHALL decode funct3: 000 add (sub when !is_imm and funct7=0x20); 001 sll; 010 slt; 011 sltu; 100 xor; 101 srl (sra when funct7=0x20); 110 or; 111 and.
REQ-014 SHALL flag illegal: R-type funct7 not in {0x00,0x20}; R-type funct7=0x20 with funct3 not in {000,101}; I-type funct3 in {001,101} with funct7 not in {0x00,0x20}; I-type funct3=001 with funct7=0x20.
REQ-015 SHALL, for I-type shifts, mask alu_in2 to imm[4:0] zero-extended; other I-type ops use imm as alu_in2; alu_in1 is always rs1_val.
REQ-016 SHALL implement stage S1 (decode register driving alu_op/alu_in1/alu_in2) and stage S2 (result register driving result/err/out_valid).
REQ-017 SHALL drive alu_op all-zero whenever S1 is empty or holds an illegal op.
REQ-018 SHALL capture in S2 result=alu_out and err=illegal OR !alu_valid; illegal ops still flow through with result=0.
REQ-019 SHALL define s2_free = !out_valid OR out_ready; S1 advances to S2 when S1 valid and s2_free.
REQ-020 SHALL assert in_ready = !s1_valid OR s2_free (combinational, no in_valid dependence).
REQ-021 SHALL accept an input on in_valid AND in_ready; latency accept-edge to out_valid = 2 cycles; sustained throughput 1 op/cycle when out_ready stays high.
REQ-022 SHALL hold result/err/out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL hold S1 contents and alu_op stable while stalled.
REQ-024 SHALL, on flush, clear both stage valids next edge, ignore same-cycle in_valid, and force in_ready=0 that cycle; flush wins over any simultaneous handshake.

Reset
REQ-025 SHALL asynchronously clear on rst: S1 valid=0, alu_op=0, alu_in1=0, alu_in2=0, out_valid=0, result=0, err=0.
REQ-026 SHALL discard any in-flight op when rst asserts mid-operation; in_ready=1 from the first edge after rst deasserts.

Structure
REQ-027 SHALL place the NR_ALU value and the ten one-hot bit-index constants in a shared package used with the ALU.
REQ-028 SHALL keep the decoder as one combinational sub-module alu_decode (funct3/funct7/is_imm -> one-hot op, illegal, shift-mask flag).

Verification
REQ-029 SHALL cover: R-type funct3=000 funct7=0x20, rs1=10, rs2=3, out_ready=1 -> alu_op=0x002 one cycle after accept, result=7, err=0, out_valid two cycles after accept.
REQ-030 SHALL cover: I-type funct3=101 funct7=0x20, rs1=0x80000000, imm=0x404 -> alu_op=0x080, alu_in2=4, result=0xF8000000.
REQ-031 SHALL cover: R-type funct3=001 funct7=0x20 -> alu_op=0, result=0, err=1.
REQ-032 SHALL cover: 4 back-to-back ops with out_ready=0 -> in_ready falls after 2 accepts, outputs stable; out_ready=1 then drains all 4 in order, one per cycle.
REQ-033 SHALL cover: flush with both stages full and in_valid=1 -> out_valid=0 and alu_op=0 next cycle, no extra op emitted.
REQ-034 SHALL cover: rst pulse mid-stream between clock edges -> all outputs zero immediately, no stale result after release.
